// File: rtl/adder_probe_pkg.sv
// Shared types and constants for the adder delay probe: FSM states, LFSR taps,
// operand-B mask and the seed used in place of an all-zero seed.
package adder_probe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_CAPTURE,
    S_COMPARE,
    S_DONE
  } probe_state_t;

  localparam int LFSR_W   = 32;
  localparam int LFSR_T3  = 31;
  localparam int LFSR_T2  = 21;
  localparam int LFSR_T1  = 1;
  localparam int LFSR_T0  = 0;

  localparam logic [LFSR_W-1:0] B_MASK       = 32'h5A5A_5A5A;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'h0000_0001;

  // One Fibonacci step, shifting left with the feedback entering at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[LFSR_T3] ^ l[LFSR_T2] ^ l[LFSR_T1] ^ l[LFSR_T0];
    return {l[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/adder_delay_probe_lfsr32.sv
// 32-bit operand generator: loads a seed (zero replaced by DEFAULT_SEED) and
// advances one Fibonacci step per enabled cycle.
module lfsr32
  import adder_probe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_lfsr;

  // An all-zero state would lock the register, so it is never allowed in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= DEFAULT_SEED;
    end else if (i_load) begin
      r_lfsr <= (i_seed == '0) ? DEFAULT_SEED : i_seed;
    end else if (i_step) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/adder_delay_probe.sv
// Launch/capture probe for a 32-bit adder: drives LFSR operands, waits a
// programmable settle window, samples the sum and counts mismatches against a
// golden sum. Optional first-fail logging when ADDER_PROBE_FAIL_LOG_EN is defined.
module adder_delay_probe
  import adder_probe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [7:0]       settle_cycles,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             C0,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] fail_idx,
  output logic [WIDTH-1:0] fail_data,
  output logic             fail_seen
);

  probe_state_t     r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c0;
  logic [WIDTH-1:0] r_golden;
  logic [WIDTH-1:0] r_cap;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_vec_idx;
  logic [CNT_W-1:0] r_err;
  logic [7:0]       r_settle;
  logic [7:0]       r_settle_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_lfsr;
  logic [WIDTH-1:0] w_b_next;
  logic             w_c0_next;
  logic [WIDTH-1:0] w_golden_next;
  logic             w_lfsr_load;
  logic             w_lfsr_step;
  logic             w_mismatch;
  logic             w_last_vec;

  assign w_lfsr_load   = (r_state == S_IDLE) && start && !abort;
  assign w_lfsr_step   = (r_state == S_LAUNCH) && !abort;
  assign w_b_next      = {w_lfsr[15:0], w_lfsr[31:16]} ^ B_MASK;
  assign w_c0_next     = w_lfsr[0];
  assign w_golden_next = w_lfsr + w_b_next + WIDTH'(w_c0_next);
  assign w_mismatch    = (r_cap != r_golden);
  assign w_last_vec    = (r_vec_idx == r_num - CNT_W'(1));

  lfsr32 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_lfsr_load),
    .i_seed  (seed),
    .i_step  (w_lfsr_step),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_c0         <= 1'b0;
      r_golden     <= '0;
      r_cap        <= '0;
      r_num        <= '0;
      r_vec_idx    <= '0;
      r_err        <= '0;
      r_settle     <= '0;
      r_settle_cnt <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num     <= num_vectors;
            r_settle  <= settle_cycles;
            r_err     <= '0;
            r_vec_idx <= '0;
            if (num_vectors == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_LAUNCH;
              r_busy  <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_a          <= w_lfsr;
          r_b          <= w_b_next;
          r_c0         <= w_c0_next;
          r_golden     <= w_golden_next;
          r_settle_cnt <= '0;
          r_state      <= (r_settle != '0) ? S_SETTLE : S_CAPTURE;
        end
        S_SETTLE: begin
          if (r_settle_cnt == r_settle - 8'd1) begin
            r_state <= S_CAPTURE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end
        S_CAPTURE: begin
          r_cap   <= result;
          r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (w_mismatch && (r_err != '1)) begin
            r_err <= r_err + CNT_W'(1);
          end
          r_vec_idx <= r_vec_idx + CNT_W'(1);
          if (w_last_vec) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_LAUNCH;
          end
        end
        S_DONE: begin
          // An empty run arrives here without the pulse armed, so it spends one
          // extra cycle raising it; a normal run arrives with it already high.
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign C0        = r_c0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err;

`ifdef ADDER_PROBE_FAIL_LOG_EN
  logic [CNT_W-1:0] r_fail_idx;
  logic [WIDTH-1:0] r_fail_data;
  logic             r_fail_seen;

  // Only the first mismatch of a run is kept; later ones leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail_idx  <= '0;
      r_fail_data <= '0;
      r_fail_seen <= 1'b0;
    end else if (!abort) begin
      if (r_state == S_IDLE && start) begin
        r_fail_idx  <= '0;
        r_fail_data <= '0;
        r_fail_seen <= 1'b0;
      end else if (r_state == S_COMPARE && w_mismatch && !r_fail_seen) begin
        r_fail_idx  <= r_vec_idx;
        r_fail_data <= r_cap;
        r_fail_seen <= 1'b1;
      end
    end
  end

  assign fail_idx  = r_fail_idx;
  assign fail_data = r_fail_data;
  assign fail_seen = r_fail_seen;
`else
  assign fail_idx  = '0;
  assign fail_data = '0;
  assign fail_seen = 1'b0;
`endif

endmodule
